// File: rtl/lego_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lego_pkg
// Purpose  : Shared LEGv8 decode definitions: opcode constants, ALU-op and
//            branch-kind enums, immediate-format enum, the decoded_t record
//            held by the decode stage's output register, and a helper that
//            classifies an instruction's immediate format.
// Revision : 1.0  initial release
// ============================================================================
package lego_pkg;

    localparam int c_REG_ADDR_W = 5;
    localparam int c_DATA_W     = 64;

    localparam logic [4:0]  c_XZR      = 5'd31;

    localparam logic [10:0] c_OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] c_OP_SUBS  = 11'b11101011000;
    localparam logic [9:0]  c_OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] c_OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR  = 11'b11111000000;
    localparam logic [5:0]  c_OP_B     = 6'b000101;
    localparam logic [7:0]  c_OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  c_OP_BCOND = 8'b01010100;
    localparam logic [4:0]  c_COND_LT  = 5'h0B;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_ORR   = 3'd3,
        ALU_PASSB = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_UNCOND = 2'd1,
        BR_CBZ    = 2'd2,
        BR_BLT    = 2'd3
    } br_kind_t;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I12  = 3'd1,
        FMT_D9   = 3'd2,
        FMT_CB19 = 3'd3,
        FMT_B26  = 3'd4
    } imm_fmt_t;

    typedef struct packed {
        logic [c_REG_ADDR_W-1:0] readReg1;
        logic [c_REG_ADDR_W-1:0] readReg2;
        logic [c_REG_ADDR_W-1:0] writeReg;
        logic                    regWrite;
        logic                    memRead;
        logic                    memWrite;
        logic                    aluSrc;
        alu_op_t                 aluOp;
        br_kind_t                branchKind;
        logic [c_DATA_W-1:0]     imm;
        logic [c_DATA_W-1:0]     pc;
        logic                    illegal;
    } decoded_t;

    // Immediate format of an instruction; FMT_NONE for R-type and illegal
    // encodings (including B.cond with any condition other than LT).
    function automatic imm_fmt_t imm_format(input logic [31:0] instr);
        imm_fmt_t fmt;
        fmt = FMT_NONE;
        if (instr[31:22] == c_OP_ADDI)
            fmt = FMT_I12;
        else if (instr[31:21] == c_OP_LDUR || instr[31:21] == c_OP_STUR)
            fmt = FMT_D9;
        else if (instr[31:24] == c_OP_CBZ)
            fmt = FMT_CB19;
        else if (instr[31:24] == c_OP_BCOND && instr[4:0] == c_COND_LT)
            fmt = FMT_CB19;
        else if (instr[31:26] == c_OP_B)
            fmt = FMT_B26;
        return fmt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Purpose  : Combinational immediate generator. Extracts the immediate field
//            selected by the instruction format and extends it to DATA_W
//            (ADDI imm12 is zero-extended, all others sign-extended, unscaled).
// Ports    : instr [31:0]      in   instruction word
//            imm   [DATA_W-1:0] out  extended immediate (0 when none)
// Revision : 1.0  initial release
// ============================================================================
module imm_gen
    import lego_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_format(instr))
            FMT_I12:  imm = {{(DATA_W-12){1'b0}},       instr[21:10]};
            FMT_D9:   imm = {{(DATA_W-9){instr[20]}},   instr[20:12]};
            FMT_CB19: imm = {{(DATA_W-19){instr[23]}},  instr[23:5]};
            FMT_B26:  imm = {{(DATA_W-26){instr[25]}},  instr[25:0]};
            default:  imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered LEGv8 instruction decode with valid/ready handshake,
//            load-use hazard detection (one bubble per pair) and flush.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready, instr, pc_in       - from fetch
//            flush                                 - kill from branch resolve
//            out_valid/out_ready                   - to downstream
//            readReg1/readReg2/writeReg            - register-file addresses
//            regWrite, memRead, memWrite, aluSrc,
//            aluOp, branchKind, imm, pc_out,
//            illegal                               - decoded control/data
// Revision : 1.0  initial release
// ============================================================================
module decode_stage
    import lego_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] readReg1,
    output logic [REG_ADDR_W-1:0] readReg2,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic                  regWrite,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  aluSrc,
    output alu_op_t               aluOp,
    output br_kind_t              branchKind,
    output logic [DATA_W-1:0]     imm,
    output logic [DATA_W-1:0]     pc_out,
    output logic                  illegal
);

    logic [DATA_W-1:0] w_imm;
    decoded_t          w_dec;
    logic              w_reads1;
    logic              w_reads2;
    logic              w_advance;
    logic              w_hazard;

    logic              r_valid;
    decoded_t          r_dec;

    imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
        .instr (instr),
        .imm   (w_imm)
    );

    // Combinational decode of the presented instruction.
    always_comb begin
        w_dec            = '0;
        w_dec.readReg1   = c_XZR;
        w_dec.readReg2   = c_XZR;
        w_dec.writeReg   = c_XZR;
        w_dec.aluOp      = ALU_ADD;
        w_dec.branchKind = BR_NONE;
        w_dec.imm        = w_imm;
        w_dec.pc         = pc_in;
        w_reads1         = 1'b0;
        w_reads2         = 1'b0;

        if (instr[31:21] == c_OP_ADDS || instr[31:21] == c_OP_SUBS) begin
            w_dec.readReg1 = instr[9:5];
            w_dec.readReg2 = instr[20:16];
            w_dec.writeReg = instr[4:0];
            w_dec.regWrite = 1'b1;
            w_dec.aluOp    = (instr[31:21] == c_OP_SUBS) ? ALU_SUB : ALU_ADD;
            w_reads1       = 1'b1;
            w_reads2       = 1'b1;
        end else if (instr[31:22] == c_OP_ADDI) begin
            w_dec.readReg1 = instr[9:5];
            w_dec.writeReg = instr[4:0];
            w_dec.regWrite = 1'b1;
            w_dec.aluSrc   = 1'b1;
            w_reads1       = 1'b1;
        end else if (instr[31:21] == c_OP_LDUR) begin
            w_dec.readReg1 = instr[9:5];
            w_dec.writeReg = instr[4:0];
            w_dec.memRead  = 1'b1;
            w_dec.regWrite = 1'b1;
            w_dec.aluSrc   = 1'b1;
            w_reads1       = 1'b1;
        end else if (instr[31:21] == c_OP_STUR) begin
            w_dec.readReg1 = instr[9:5];
            w_dec.readReg2 = instr[4:0];
            w_dec.memWrite = 1'b1;
            w_dec.aluSrc   = 1'b1;   // address is base + offset
            w_reads1       = 1'b1;
            w_reads2       = 1'b1;
        end else if (instr[31:24] == c_OP_CBZ) begin
            w_dec.readReg2   = instr[4:0];
            w_dec.aluOp      = ALU_PASSB;
            w_dec.branchKind = BR_CBZ;
            w_reads2         = 1'b1;
        end else if (instr[31:24] == c_OP_BCOND && instr[4:0] == c_COND_LT) begin
            w_dec.branchKind = BR_BLT;
        end else if (instr[31:26] == c_OP_B) begin
            w_dec.branchKind = BR_UNCOND;
        end else begin
            w_dec.illegal = 1'b1;
        end

        // Writes to XZR are architecturally discarded.
        w_dec.regWrite = w_dec.regWrite && (w_dec.writeReg != c_XZR);
    end

    assign w_advance = !r_valid || out_ready;

    // Load-use: the held instruction is a load whose result the presented
    // instruction consumes in one of the registers it actually reads.
    assign w_hazard = in_valid && r_valid && r_dec.memRead &&
                      (r_dec.writeReg != c_XZR) &&
                      ((w_reads1 && (w_dec.readReg1 == r_dec.writeReg)) ||
                       (w_reads2 && (w_dec.readReg2 == r_dec.writeReg)));

    // A flushed instruction is consumed so fetch can move on.
    assign in_ready = flush || (w_advance && !w_hazard);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_dec   <= '0;
        end else if (w_advance) begin
            if (in_valid && !w_hazard) begin
                r_valid <= 1'b1;
                r_dec   <= w_dec;
            end else begin
                r_valid <= 1'b0;
                r_dec   <= '0;
            end
        end
    end

    assign out_valid  = r_valid;
    assign readReg1   = r_dec.readReg1;
    assign readReg2   = r_dec.readReg2;
    assign writeReg   = r_dec.writeReg;
    assign regWrite   = r_dec.regWrite;
    assign memRead    = r_dec.memRead;
    assign memWrite   = r_dec.memWrite;
    assign aluSrc     = r_dec.aluSrc;
    assign aluOp      = r_dec.aluOp;
    assign branchKind = r_dec.branchKind;
    assign imm        = r_dec.imm;
    assign pc_out     = r_dec.pc;
    assign illegal    = r_dec.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Directed self-checking bench for decode_stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;
    import lego_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] pc_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        aluSrc;
    alu_op_t     aluOp;
    br_kind_t    branchKind;
    logic [63:0] imm;
    logic [63:0] pc_out;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    decode_stage #(.REG_ADDR_W(5), .DATA_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc_in      (pc_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .writeReg   (writeReg),
        .regWrite   (regWrite),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .aluSrc     (aluSrc),
        .aluOp      (aluOp),
        .branchKind (branchKind),
        .imm        (imm),
        .pc_out     (pc_out),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [63:0] p);
        instr    = i;
        pc_in    = p;
        in_valid = 1'b1;
    endtask

    // Small table for branch / store / illegal-condition encodings.
    typedef struct {
        string       name;
        logic [31:0] word;
        logic [1:0]  br;
        logic [63:0] im;
        logic        ill;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"stur",  32'hF81FF0C5, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1] = '{"blt",   32'h5400008B, 2'd3, 64'd4,                   1'b0};
        vecs[2] = '{"b",     32'h17FFFFFF, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[3] = '{"b_eq",  32'h54000080, 2'd0, 64'd0,                   1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'h0;
        pc_in     = 64'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_writeReg",  64'(writeReg),  64'd0);
        check("rst_readReg1",  64'(readReg1),  64'd0);
        check("rst_imm",       imm,            64'd0);
        check("rst_pc_out",    pc_out,         64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        reset = 1'b0;

        // ADDI X1,X2,#5
        drive(32'h91001441, 64'h100);
        step();
        check("addi_valid",    64'(out_valid), 64'd1);
        check("addi_rr1",      64'(readReg1),  64'd2);
        check("addi_wr",       64'(writeReg),  64'd1);
        check("addi_regWrite", 64'(regWrite),  64'd1);
        check("addi_aluSrc",   64'(aluSrc),    64'd1);
        check("addi_imm",      imm,            64'd5);
        check("addi_pc",       pc_out,         64'h100);

        // LDUR X3,[X1,#8] then ADDS X4,X3,X3 -> one bubble
        drive(32'hF8408023, 64'h104);
        step();
        check("ldur_memRead",  64'(memRead),   64'd1);
        check("ldur_wr",       64'(writeReg),  64'd3);
        check("ldur_imm",      imm,            64'd8);
        check("ldur_rr1",      64'(readReg1),  64'd1);
        drive(32'hAB030064, 64'h108);
        #1;
        check("hz_in_ready",   64'(in_ready),  64'd0);
        step();
        check("bubble_valid",  64'(out_valid), 64'd0);
        check("bubble_ready",  64'(in_ready),  64'd1);
        step();
        check("adds_valid",    64'(out_valid), 64'd1);
        check("adds_rr1",      64'(readReg1),  64'd3);
        check("adds_rr2",      64'(readReg2),  64'd3);
        check("adds_wr",       64'(writeReg),  64'd4);
        check("adds_aluOp",    64'(aluOp),     64'd0);
        check("adds_pc",       pc_out,         64'h108);

        // CBZ X0,#-2
        drive(32'hB4FFFFC0, 64'h10C);
        step();
        check("cbz_br",        64'(branchKind), 64'd2);
        check("cbz_rr2",       64'(readReg2),   64'd0);
        check("cbz_regWrite",  64'(regWrite),   64'd0);
        check("cbz_imm",       imm,             64'hFFFF_FFFF_FFFF_FFFE);
        check("cbz_aluOp",     64'(aluOp),      64'd4);

        // ADDS X31,X1,X2 then LDUR X31 then reader of X31: no bubble
        drive(32'hAB02003F, 64'h110);
        step();
        check("xzr_wr",        64'(writeReg),  64'd31);
        check("xzr_regWrite",  64'(regWrite),  64'd0);
        drive(32'hF840001F, 64'h114);
        step();
        check("ldx31_memRead", 64'(memRead),   64'd1);
        check("ldx31_regWr",   64'(regWrite),  64'd0);
        drive(32'hAB1F03E5, 64'h118);
        #1;
        check("x31_in_ready",  64'(in_ready),  64'd1);
        step();
        check("x31_reader_v",  64'(out_valid), 64'd1);
        check("x31_reader_wr", 64'(writeReg),  64'd5);

        // Store, branches, and B.cond with an unsupported condition
        for (int k = 0; k < 4; k++) begin
            drive(vecs[k].word, 64'h200 + 64'(k * 4));
            step();
            check({vecs[k].name, "_br"},  64'(branchKind), 64'(vecs[k].br));
            check({vecs[k].name, "_imm"}, imm,             vecs[k].im);
            check({vecs[k].name, "_ill"}, 64'(illegal),    64'(vecs[k].ill));
        end
        check("stur_memWrite_after_loop", 64'(memWrite), 64'd0);

        // Backpressure for 3 cycles, then flush drops the presented instr
        drive(32'h91001441, 64'h300);
        step();
        out_ready = 1'b0;
        drive(32'hAB030064, 64'h304);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_in_ready", 64'(in_ready), 64'd0);
            step();
            check("stall_pc",       pc_out,         64'h300);
            check("stall_valid",    64'(out_valid), 64'd1);
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready),  64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_valid",    64'(out_valid), 64'd0);
        step();
        check("flush_dropped",  64'(out_valid), 64'd0);

        // Flush during a load-use hazard
        drive(32'hF8408023, 64'h400);
        step();
        drive(32'hAB030064, 64'h404);
        flush = 1'b1;
        #1;
        check("flush_hz_ready", 64'(in_ready),  64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_hz_valid", 64'(out_valid), 64'd0);

        // Illegal all-zero word
        drive(32'h00000000, 64'h500);
        step();
        check("ill_valid",     64'(out_valid),  64'd1);
        check("ill_flag",      64'(illegal),    64'd1);
        check("ill_regWrite",  64'(regWrite),   64'd0);
        check("ill_memWrite",  64'(memWrite),   64'd0);
        check("ill_br",        64'(branchKind), 64'd0);

        // Asynchronous reset in the middle of a stall
        drive(32'hF8408023, 64'h600);
        step();
        out_ready = 1'b0;
        drive(32'hAB030064, 64'h604);
        step();
        check("pre_rst_memRead", 64'(memRead), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid",    64'(out_valid), 64'd0);
        check("arst_memRead",  64'(memRead),   64'd0);
        check("arst_wr",       64'(writeReg),  64'd0);
        check("arst_imm",      imm,            64'd0);
        check("arst_pc",       pc_out,         64'd0);
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("arst_no_retain", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
